// File: rtl/hermes_inj_arbiter_pkg.sv
// Shared types for the Hermes injector-sharing arbiter.
package hermes_inj_arbiter_pkg;

    // Packet-level arbiter phases: idle, then the three flit kinds of a Hermes packet.
    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        SIZE,
        PAYLOAD
    } hermes_arb_state_t;

endpackage

// File: rtl/hermes_inj_arbiter_if.sv
// Injector-side and router-side flit handshake bundle for the arbiter.
interface hermes_inj_arbiter_if #(
    parameter int N_SRC     = 2,
    parameter int FLIT_SIZE = 32
);
    localparam int GNT_W = $clog2(N_SRC);

    logic                 enable_i;
    logic [N_SRC-1:0]     src_rx_i;
    logic [N_SRC-1:0]     src_credit_o;
    logic [FLIT_SIZE-1:0] src_data_i [N_SRC];
    logic                 noc_tx_o;
    logic                 noc_credit_i;
    logic [FLIT_SIZE-1:0] noc_data_o;
    logic [GNT_W-1:0]     grant_o;
    logic                 busy_o;

    // Arbiter side.
    modport master (
        input  enable_i, src_rx_i, src_data_i, noc_credit_i,
        output src_credit_o, noc_tx_o, noc_data_o, grant_o, busy_o
    );

    // Environment side (injectors plus router).
    modport slave (
        output enable_i, src_rx_i, src_data_i, noc_credit_i,
        input  src_credit_o, noc_tx_o, noc_data_o, grant_o, busy_o
    );
endinterface

// File: rtl/hermes_inj_arbiter_rr_arbiter.sv
// Combinational rotating-priority picker: first requester at or after pointer.
module rr_arbiter #(
    parameter int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] pointer,
    output logic [W-1:0] gnt,
    output logic         valid
);

    // Scan from pointer upward with wrap; first hit wins.
    always_comb begin
        int unsigned k;
        logic [W-1:0] idx;
        k     = 0;
        idx   = '0;
        gnt   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < unsigned'(N); i++) begin
            k = 32'(pointer) + i;
            if (k >= unsigned'(N)) begin
                k = k - unsigned'(N);
            end
            idx = W'(k);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                gnt   = idx;
            end
        end
    end

endmodule

// File: rtl/hermes_inj_arbiter.sv
// Packet-level round-robin arbiter sharing one Hermes router port between
// several credit-based injectors; whole packets are granted, never interleaved.
module hermes_inj_arbiter
    import hermes_inj_arbiter_pkg::*;
#(
    parameter int N_SRC     = 2,
    parameter int FLIT_SIZE = 32,
    parameter int SIZE_W    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    hermes_inj_arbiter_if.master  bus
);

    localparam int GNT_W = $clog2(N_SRC);

    hermes_arb_state_t    state_q, state_d;
    logic [GNT_W-1:0]     grant_q, grant_d;
    logic [GNT_W-1:0]     ptr_q, ptr_d;
    logic [SIZE_W-1:0]    cnt_q, cnt_d;

    logic [GNT_W-1:0]     pick;
    logic                 pick_valid;
    logic                 sel_rx;
    logic [FLIT_SIZE-1:0] sel_data;
    logic                 xfer;
    logic [GNT_W-1:0]     ptr_after;

    rr_arbiter #(.N(N_SRC)) u_rr (
        .req     (bus.src_rx_i),
        .pointer (ptr_q),
        .gnt     (pick),
        .valid   (pick_valid)
    );

    // Granted-source view and the flit-moves condition.
    always_comb begin
        sel_rx    = bus.src_rx_i[grant_q];
        sel_data  = bus.src_data_i[grant_q];
        xfer      = (state_q != IDLE) && bus.enable_i && sel_rx && bus.noc_credit_i;
        ptr_after = (grant_q == GNT_W'(N_SRC - 1)) ? '0 : grant_q + GNT_W'(1);
    end

    // State, grant, pointer and length counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: arbitrate in IDLE, then walk header/size/payload on transfers.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.enable_i && pick_valid) begin
                    grant_d = pick;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (xfer) begin
                    state_d = SIZE;
                end
            end
            SIZE: begin
                if (xfer) begin
                    cnt_d = sel_data[SIZE_W-1:0];
                    if (sel_data[SIZE_W-1:0] == '0) begin
                        state_d = IDLE;
                        ptr_d   = ptr_after;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    cnt_d = cnt_q - SIZE_W'(1);
                    if (cnt_q == SIZE_W'(1)) begin
                        state_d = IDLE;
                        ptr_d   = ptr_after;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Combinational flit mux and credit steering toward the granted source.
    always_comb begin
        bus.src_credit_o = '0;
        bus.noc_tx_o     = 1'b0;
        bus.noc_data_o   = '0;
        if (state_q != IDLE) begin
            bus.noc_tx_o              = sel_rx & bus.enable_i;
            bus.noc_data_o            = sel_data;
            bus.src_credit_o[grant_q] = bus.noc_credit_i & bus.enable_i;
        end
        bus.busy_o  = (state_q != IDLE);
        bus.grant_o = grant_q;
    end

endmodule

// File: tb/tb_hermes_inj_arbiter.sv
// Self-checking bench for hermes_inj_arbiter: table vectors, directed corner
// sequences and randomized traffic against a flit-counting packet model.
module tb_hermes_inj_arbiter;
    localparam int N  = 2;
    localparam int FW = 32;
    localparam int SW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hermes_inj_arbiter_if #(.N_SRC(N), .FLIT_SIZE(FW)) bus ();

    hermes_inj_arbiter #(.N_SRC(N), .FLIT_SIZE(FW), .SIZE_W(SW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Source streams and environment controls
    logic [31:0] sq [N][$];
    logic [N-1:0] gate;
    logic         en;
    logic         cr;
    int           cr_mode;
    logic [N-1:0] rxv;
    logic [31:0]  dv [N];

    // Reference model: packet owner plus flits sent / flits expected
    int m_busy, m_owner, m_ptr, m_sent, m_total, m_grant;
    logic [31:0] out_q[$];
    logic [31:0] exp_q[$];
    int          glog[$];
    int          pushed;

    // Table vectors
    typedef struct {
        logic        en;
        logic        cr;
        logic [1:0]  gate;
        logic        tx;
        logic [31:0] data;
        logic [1:0]  credit;
        logic        grant;
        logic        busy;
    } vec_t;
    vec_t tbl [8];
    bit   tbl_on;
    vec_t tv;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_sent = 0; m_total = -1; m_grant = 0;
    endtask

    task automatic push_pkt(input int s, input logic [31:0] hdr, input logic [15:0] upper, input int n);
        logic [31:0] f;
        sq[s].push_back(hdr);          exp_q.push_back(hdr);
        f = {upper, 16'(n)};
        sq[s].push_back(f);            exp_q.push_back(f);
        for (int i = 0; i < n; i++) begin
            f = {4'(s + 1), 12'(i), 16'($urandom)};
            sq[s].push_back(f);        exp_q.push_back(f);
        end
        pushed += n + 2;
    endtask

    task automatic drive();
        for (int s = 0; s < N; s++) begin
            rxv[s] = gate[s] && (sq[s].size() > 0);
            dv[s]  = (sq[s].size() > 0) ? sq[s][0] : (32'hBAD0_0000 | 32'(s));
        end
        bus.src_rx_i     = rxv;
        bus.src_data_i   = dv;
        bus.enable_i     = en;
        bus.noc_credit_i = cr;
    endtask

    task automatic step();
        logic         ex_tx;
        logic [31:0]  ex_d;
        logic [N-1:0] ex_cr;
        bit           found;
        drive();
        #1;
        ex_tx = 1'b0; ex_d = '0; ex_cr = '0;
        if (m_busy != 0) begin
            ex_tx = rxv[m_owner] & en;
            ex_d  = dv[m_owner];
            ex_cr[m_owner] = cr & en;
        end
        chk("noc_tx", 32'(bus.noc_tx_o), 32'(ex_tx));
        chk("noc_data", bus.noc_data_o, ex_d);
        chk("src_credit", 32'(bus.src_credit_o), 32'(ex_cr));
        chk("grant", 32'(bus.grant_o), 32'(m_grant));
        chk("busy", 32'(bus.busy_o), 32'(m_busy));
        if (tbl_on) begin
            chk("tbl_tx", 32'(bus.noc_tx_o), 32'(tv.tx));
            chk("tbl_data", bus.noc_data_o, tv.data);
            chk("tbl_credit", 32'(bus.src_credit_o), 32'(tv.credit));
            chk("tbl_grant", 32'(bus.grant_o), 32'(tv.grant));
            chk("tbl_busy", 32'(bus.busy_o), 32'(tv.busy));
        end
        if (m_busy == 0) begin
            found = 0;
            if (en) begin
                for (int i = 0; i < N; i++) begin
                    int s;
                    s = (m_ptr + i) % N;
                    if (!found && rxv[s]) begin
                        found = 1; m_busy = 1; m_owner = s; m_grant = s;
                        m_sent = 0; m_total = -1; glog.push_back(s);
                    end
                end
            end
        end else if (en && rxv[m_owner] && cr) begin
            out_q.push_back(dv[m_owner]);
            void'(sq[m_owner].pop_front());
            if (m_sent == 1) m_total = 2 + int'(dv[m_owner][SW-1:0]);
            m_sent++;
            if (m_sent == m_total) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cr();
        case (cr_mode)
            1:       cr = ~cr;
            2:       cr = ($urandom % 4) != 0;
            default: cr = 1'b1;
        endcase
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sq[0].size() > 0 || sq[1].size() > 0 || m_busy != 0) && guard < 400) begin
            set_cr();
            step();
            guard++;
        end
        chk("drain_timeout", 32'(guard < 400), 32'd1);
    endtask

    task automatic cmp_out(input string name);
        chk({name, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            chk(name, out_q[i], exp_q[i]);
    endtask

    task automatic clear_logs();
        out_q.delete(); exp_q.delete(); glog.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        for (int s = 0; s < N; s++) sq[s].delete();
        clear_logs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; cr = 1'b1; gate = '1; cr_mode = 0; tbl_on = 0; pushed = 0;
        bus.src_rx_i = '0; bus.enable_i = 1'b0; bus.noc_credit_i = 1'b0;
        for (int s = 0; s < N; s++) bus.src_data_i[s] = '0;
        model_reset();
        #2;
        chk("rst_tx", 32'(bus.noc_tx_o), 32'd0);
        chk("rst_credit", 32'(bus.src_credit_o), 32'd0);
        chk("rst_data", bus.noc_data_o, 32'd0);
        chk("rst_grant", 32'(bus.grant_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        do_reset();

        // Single src0 packet, size 3, with one credit-low stall
        tbl[0] = '{1'b1, 1'b1, 2'b01, 1'b0, 32'h0,     2'b00, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 2'b01, 1'b1, 32'h0101,  2'b01, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 2'b01, 1'b1, 32'h0003,  2'b01, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 2'b01, 1'b1, 32'h000A,  2'b01, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h000B,  2'b00, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 2'b01, 1'b1, 32'h000B,  2'b01, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 2'b01, 1'b1, 32'h000C,  2'b01, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 2'b01, 1'b0, 32'h0,     2'b00, 1'b0, 1'b0};
        sq[0].push_back(32'h0101); sq[0].push_back(32'h0003);
        sq[0].push_back(32'h000A); sq[0].push_back(32'h000B); sq[0].push_back(32'h000C);
        tbl_on = 1;
        for (int i = 0; i < 8; i++) begin
            tv = tbl[i]; en = tv.en; cr = tv.cr; gate = tv.gate;
            step();
        end
        tbl_on = 0; gate = '1; cr = 1'b1;
        // Pointer now at 1: simultaneous requests go to src1
        clear_logs();
        push_pkt(0, 32'h0000_0110, 16'h0, 0);
        push_pkt(1, 32'h0000_0210, 16'h0, 0);
        drain();
        chk("ptr_after_pkt0", 32'(glog.size() > 0 ? glog[0] : -1), 32'd1);

        // Simultaneous requests after reset: src0 then src1, no interleave
        do_reset();
        push_pkt(0, 32'h0000_0100, 16'h0, 1);
        push_pkt(1, 32'h0000_0200, 16'h0, 2);
        drain();
        chk("seq2_grants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            chk("seq2_g0", 32'(glog[0]), 32'd0);
            chk("seq2_g1", 32'(glog[1]), 32'd1);
        end
        cmp_out("seq2_flit");

        // Zero-length src1 packet (upper bits of size flit set), then src0
        clear_logs();
        push_pkt(1, 32'h0000_0300, 16'hFFFF, 0);
        step();
        push_pkt(0, 32'h0000_0400, 16'h0, 1);
        drain();
        chk("seq3_grants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            chk("seq3_g0", 32'(glog[0]), 32'd1);
            chk("seq3_g1", 32'(glog[1]), 32'd0);
        end
        cmp_out("seq3_flit");

        // Router credit toggling during a 4-flit payload
        clear_logs();
        cr_mode = 1; cr = 1'b0;
        push_pkt(0, 32'h0000_0500, 16'h0, 4);
        drain();
        cmp_out("seq4_flit");
        cr_mode = 0;

        // Enable drop mid-payload with two flits left
        clear_logs();
        push_pkt(0, 32'h0000_0600, 16'h0, 4);
        for (int g = 0; g < 50 && !(m_total > 0 && m_total - m_sent == 2); g++) begin
            cr = 1'b1; step();
        end
        chk("seq5_reach", 32'(m_total - m_sent), 32'd2);
        en = 1'b0;
        repeat (5) step();
        chk("seq5_hold_busy", 32'(bus.busy_o), 32'd1);
        en = 1'b1;
        drain();
        cmp_out("seq5_flit");
        // Enable low in IDLE blocks arbitration
        clear_logs();
        en = 1'b0;
        push_pkt(1, 32'h0000_0700, 16'h0, 1);
        repeat (4) step();
        chk("seq5_no_grant", 32'(bus.busy_o), 32'd0);
        en = 1'b1;
        drain();
        cmp_out("seq5b_flit");

        // Asynchronous reset mid-payload of a src1 packet
        clear_logs();
        push_pkt(1, 32'h0000_0800, 16'h0, 5);
        for (int g = 0; g < 50 && m_sent < 3; g++) step();
        chk("seq6_grant_pre", 32'(bus.grant_o), 32'd1);
        drive();
        #2 rst = 1'b1;
        #1;
        chk("seq6_rst_tx", 32'(bus.noc_tx_o), 32'd0);
        chk("seq6_rst_credit", 32'(bus.src_credit_o), 32'd0);
        chk("seq6_rst_data", bus.noc_data_o, 32'd0);
        chk("seq6_rst_grant", 32'(bus.grant_o), 32'd0);
        chk("seq6_rst_busy", 32'(bus.busy_o), 32'd0);
        do_reset();
        push_pkt(1, 32'h0000_0900, 16'h0, 2);
        drain();
        chk("seq6_regrant", 32'(glog.size() > 0 ? glog[0] : -1), 32'd1);
        cmp_out("seq6_flit");

        // Randomized traffic against the model
        clear_logs();
        pushed = 0;
        cr_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            for (int s = 0; s < N; s++)
                if (sq[s].size() == 0 && ($urandom % 3) == 0)
                    push_pkt(s, $urandom, 16'($urandom), int'($urandom_range(0, 5)));
            gate = N'($urandom);
            en   = ($urandom % 10) != 0;
            set_cr();
            step();
        end
        gate = '1; en = 1'b1;
        drain();
        chk("rand_flits", 32'(out_q.size()), 32'(pushed));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/hermes_inj_arbiter.md
Name: hermes_inj_arbiter

Overview:
- Packet-level round-robin arbiter that shares one Hermes local/boundary port between N_SRC credit-based injectors, e.g. the MA and App task injectors on a single boundary router port.
- Sits between the injectors' NoC transmit side and the PE router input.
- Grants whole Hermes packets (header, size, payload) without interleaving.
- Tracks packet length from the size flit to find packet end.

Parameters:
- N_SRC, 2, number of requesting injectors (>=2).
- FLIT_SIZE, 32, flit width in bits.
- SIZE_W, 16, width of the payload-length counter; taken from size flit bits [SIZE_W-1:0].

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- enable_i  in  1  port release/enable (release_peripheral-style gate)
- src_rx_i  in  N_SRC  per-source flit valid
- src_credit_o  out  N_SRC  per-source credit (ready)
- src_data_i  in  N_SRC x FLIT_SIZE  per-source flit data (unpacked array)
- noc_tx_o  out  1  flit valid to router
- noc_credit_i  in  1  router credit
- noc_data_o  out  FLIT_SIZE  flit to router
- grant_o  out  $clog2(N_SRC)  current/last granted source
- busy_o  out  1  packet in progress

Behaviour:
- Reset (async, rst_i=1): state IDLE, grant_o=0, rr pointer=0 (source 0 highest priority), counter=0. All src_credit_o=0, noc_tx_o=0, noc_data_o=0, busy_o=0.
- Transfer definition: a flit moves when state≠IDLE, enable_i=1, src_rx_i[g]=1 and noc_credit_i=1 (g = grant). Datapath is combinational while granted:
  - noc_tx_o = src_rx_i[g] & enable_i
  - noc_data_o = src_data_i[g]
  - src_credit_o[g] = noc_credit_i & enable_i
  - Non-granted src_credit_o = 0.
  - noc_data_o = 0 when IDLE.
- FSM states: IDLE, HEADER, SIZE, PAYLOAD.
  - IDLE: if enable_i=1 and any src_rx_i=1, pick the first requesting source at or after the rr pointer (wrapping modulo N_SRC). Register grant_o and go to HEADER. Arbitration latency is 1 cycle; the header can move in the following cycle at the earliest. enable_i=0 blocks grants.
  - HEADER: on transfer -> SIZE.
  - SIZE: on transfer, load counter = src_data_i[g][SIZE_W-1:0]. If that value = 0 -> IDLE (packet done); else -> PAYLOAD.
  - PAYLOAD: on each transfer, counter-1. The transfer with counter=1 is the last; -> IDLE.
  - On every return to IDLE: rr pointer = g+1 mod N_SRC.
- No transfer in a cycle (credit low, rx low, or enable low): state, counter and grant hold. A mid-packet enable_i drop stalls; it does not abort.
- Grant never changes mid-packet, even if the granted source drops rx.
- busy_o = (state≠IDLE).
- Simultaneous requests resolve by rr pointer. The same source cannot win twice in a row while another is requesting.
- Back-to-back packets: the next grant costs one IDLE cycle (1 bubble per packet).
- Counter width: SIZE_W bits, unsigned, no wrap needed. Size flit bits above SIZE_W are ignored.
- Reset mid-packet: immediate return to IDLE with all outputs low. The partial packet is not completed; the sources must reset together.

Decomposition:
- HermesPkg gains typedef hermes_arb_state_t (IDLE, HEADER, SIZE, PAYLOAD).
- Sub-module rr_arbiter(N): combinational rotating-priority picker with inputs req and pointer, outputs gnt index and valid. Reusable for BrLite-side sharing.
- Top holds the FSM, counter, pointer and mux.

Test Plan:
- Single packet from src0, payload size 3: header 0x0000_0101, size 0x0000_0003, payloads A,B,C -> 5 flits on noc_data_o in order. busy_o rises 1 cycle after src_rx_i[0]. Returns to IDLE after C. Pointer becomes 1.
- Both sources request in the same cycle after reset -> src0 granted first (full packet), then src1 after a 1-cycle bubble. grant_o sequence 0,1. No flit interleaving.
- Zero-length packet (size flit 0x0) from src1 -> exactly 2 flits forwarded; FSM back to IDLE after the size flit; src0 granted next.
- noc_credit_i toggles 1/0 every cycle during a 4-flit payload -> each flit transferred exactly once. Counter decrements only on credit-high cycles. Source credit mirrors noc_credit_i.
- enable_i deasserted in PAYLOAD with counter=2 for 5 cycles -> noc_tx_o=0 and src_credit_o=0. State holds; the remaining 2 flits complete after re-enable. enable_i=0 in IDLE with requests pending -> no grant.
- rst_i pulsed mid-PAYLOAD -> all outputs 0 asynchronously, grant_o=0. After release, a new src1 packet is arbitrated normally from IDLE.
